// File: rtl/compute_arbiter.sv
// compute_arbiter: round-robin sharing of one fixed-latency compute device between two clients
module compute_arbiter #(
    parameter int WIDTH   = 4,
    parameter int DEV_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c0_req_valid,
    output logic             c0_req_ready,
    input  logic [WIDTH-1:0] c0_y,
    input  logic [1:0]       c0_opcode,
    output logic             c0_rsp_valid,
    input  logic             c0_rsp_ready,
    output logic [WIDTH-1:0] c0_rsp_result,
    input  logic             c1_req_valid,
    output logic             c1_req_ready,
    input  logic [WIDTH-1:0] c1_y,
    input  logic [1:0]       c1_opcode,
    output logic             c1_rsp_valid,
    input  logic             c1_rsp_ready,
    output logic [WIDTH-1:0] c1_rsp_result,
    output logic             dev_req,
    output logic [WIDTH-1:0] dev_y,
    output logic [1:0]       dev_opcode,
    input  logic [WIDTH-1:0] dev_result,
    output logic             busy,
    output logic             grant_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           r_state, w_next;
    logic             r_last_grant, r_job_id;
    logic [WIDTH-1:0] r_job_y, r_res0, r_res1;
    logic [1:0]       r_job_op;
    logic [3:0]       r_cnt;
    logic             w_win, w_accept, w_rsp_hs, w_done;

    // Arbitration winner, handshake decodes and next state
    always_comb begin
        w_win    = (c0_req_valid && c1_req_valid) ? ~r_last_grant : c1_req_valid;
        w_accept = (r_state == IDLE) && (c0_req_valid || c1_req_valid);
        w_rsp_hs = (r_state == RESP) && (r_job_id ? c1_rsp_ready : c0_rsp_ready);
        w_done   = (r_state == WAIT) && (r_cnt == 4'd1);
        w_next   = (r_state == IDLE)  ? (w_accept ? ISSUE : IDLE) :
                   (r_state == ISSUE) ? WAIT :
                   (r_state == WAIT)  ? (w_done ? RESP : WAIT) :
                   (w_rsp_hs ? IDLE : RESP);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Job registers latched on request accept; they also drive the device inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_job_y  <= '0;
            r_job_op <= '0;
            r_job_id <= 1'b0;
        end else if (w_accept) begin
            r_job_y  <= w_win ? c1_y : c0_y;
            r_job_op <= w_win ? c1_opcode : c0_opcode;
            r_job_id <= w_win;
        end
    end

    // Round-robin history updates only when a response is delivered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_last_grant <= 1'b1;
        else if (w_rsp_hs) r_last_grant <= r_job_id;
    end

    // Device latency counter: loaded at issue, counts down through WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  r_cnt <= '0;
        else if (r_state == ISSUE)   r_cnt <= 4'(DEV_LAT);
        else if (r_state == WAIT)    r_cnt <= r_cnt - 4'd1;
    end

    // Capture device result into the owner's result register at the end of WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res0 <= '0;
            r_res1 <= '0;
        end else if (w_done) begin
            if (r_job_id) r_res1 <= dev_result;
            else          r_res0 <= dev_result;
        end
    end

    // Ready is gated by reset so nothing is offered while reset is asserted
    assign c0_req_ready  = reset && (r_state == IDLE) && c0_req_valid && !w_win;
    assign c1_req_ready  = reset && (r_state == IDLE) && c1_req_valid && w_win;
    assign c0_rsp_valid  = (r_state == RESP) && !r_job_id;
    assign c1_rsp_valid  = (r_state == RESP) && r_job_id;
    assign c0_rsp_result = r_res0;
    assign c1_rsp_result = r_res1;
    assign dev_req       = (r_state == ISSUE);
    assign dev_y         = r_job_y;
    assign dev_opcode    = r_job_op;
    assign busy          = (r_state != IDLE);
    assign grant_id      = r_job_id;
endmodule

// File: tb/tb_compute_arbiter.sv
// tb_compute_arbiter: scoreboard bench for compute_arbiter with DEV_LAT=1 and DEV_LAT=3 instances
module tb_compute_arbiter;
    logic       clk = 1'b0;
    logic       reset, rst3;
    logic       c0_req_valid, c1_req_valid, c0_rsp_ready, c1_rsp_ready;
    logic [3:0] c0_y, c1_y;
    logic [1:0] c0_opcode, c1_opcode;
    logic       c0_req_ready, c1_req_ready, c0_rsp_valid, c1_rsp_valid, dev_req, busy, grant_id;
    logic [3:0] c0_rsp_result, c1_rsp_result, dev_y, dev_result;
    logic [1:0] dev_opcode;
    logic       b_c0_req_ready, b_c1_req_ready, b_c0_rsp_valid, b_c1_rsp_valid, b_dev_req, b_busy, b_grant_id;
    logic [3:0] b_c0_rsp_result, b_c1_rsp_result, b_dev_y, b_dev_result;
    logic [1:0] b_dev_opcode;
    logic [3:0] s1;
    logic [3:0] s3 [3];
    logic [4:0] sb [$];
    int         n_tests = 0, n_fail = 0, n_rsp = 0;

    always #5 clk = ~clk;

    compute_arbiter #(.WIDTH(4), .DEV_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_y(c0_y), .c0_opcode(c0_opcode),
        .c0_rsp_valid(c0_rsp_valid), .c0_rsp_ready(c0_rsp_ready), .c0_rsp_result(c0_rsp_result),
        .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_y(c1_y), .c1_opcode(c1_opcode),
        .c1_rsp_valid(c1_rsp_valid), .c1_rsp_ready(c1_rsp_ready), .c1_rsp_result(c1_rsp_result),
        .dev_req(dev_req), .dev_y(dev_y), .dev_opcode(dev_opcode), .dev_result(dev_result),
        .busy(busy), .grant_id(grant_id)
    );

    compute_arbiter #(.WIDTH(4), .DEV_LAT(3)) u_dut3 (
        .clk(clk), .reset(rst3),
        .c0_req_valid(c0_req_valid), .c0_req_ready(b_c0_req_ready), .c0_y(c0_y), .c0_opcode(c0_opcode),
        .c0_rsp_valid(b_c0_rsp_valid), .c0_rsp_ready(c0_rsp_ready), .c0_rsp_result(b_c0_rsp_result),
        .c1_req_valid(c1_req_valid), .c1_req_ready(b_c1_req_ready), .c1_y(c1_y), .c1_opcode(c1_opcode),
        .c1_rsp_valid(b_c1_rsp_valid), .c1_rsp_ready(c1_rsp_ready), .c1_rsp_result(b_c1_rsp_result),
        .dev_req(b_dev_req), .dev_y(b_dev_y), .dev_opcode(b_dev_opcode), .dev_result(b_dev_result),
        .busy(b_busy), .grant_id(b_grant_id)
    );

    // Device stubs: correct value DEV_LAT cycles after dev_req, its complement otherwise
    always @(posedge clk or negedge reset) begin
        if (!reset) s1 <= '0;
        else        s1 <= dev_req ? dev_y + {2'b0, dev_opcode} : ~(dev_y + {2'b0, dev_opcode});
    end
    always @(posedge clk or negedge rst3) begin
        if (!rst3) s3 <= '{default: '0};
        else begin
            s3[0] <= b_dev_req ? b_dev_y + {2'b0, b_dev_opcode} : ~(b_dev_y + {2'b0, b_dev_opcode});
            s3[1] <= s3[0];
            s3[2] <= s3[1];
        end
    end
    assign dev_result   = s1;
    assign b_dev_result = s3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard on the DEV_LAT=1 instance: push on accept, pop and compare on response
    always @(negedge clk) begin
        logic [4:0] e;
        if (c0_req_valid && c0_req_ready) sb.push_back({1'b0, c0_y + {2'b0, c0_opcode}});
        if (c1_req_valid && c1_req_ready) sb.push_back({1'b1, c1_y + {2'b0, c1_opcode}});
        if ((c0_rsp_valid && c0_rsp_ready) || (c1_rsp_valid && c1_rsp_ready)) begin
            n_rsp++;
            if (sb.size() == 0) check("rsp_unexpected", sb.size(), 1);
            else begin
                e = sb.pop_front();
                check("rsp", {c1_rsp_valid, c1_rsp_valid ? c1_rsp_result : c0_rsp_result}, e);
                check("rsp_grant_id", grant_id, e[4]);
                check("rsp_onehot", c0_rsp_valid & c1_rsp_valid, 0);
            end
        end
    end

    task automatic drain(input string tag);
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        check(tag, {busy, sb.size() != 0}, 0);
    endtask

    task automatic single(input logic [3:0] y, input logic [1:0] op, input logic [3:0] exp);
        logic [4:0] dr, rv;
        logic       c1v;
        dr = '0; rv = '0; c1v = 1'b0;
        @(posedge clk); #1;
        c0_y = y; c0_opcode = op; c0_req_valid = 1'b1; c1_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dr[i] = dev_req; rv[i] = c0_rsp_valid; c1v |= c1_rsp_valid;
            if (i == 0) check("single_accept", c0_req_ready, 1);
            if (i == 1) check("single_dev_in", {dev_y, dev_opcode}, {y, op});
            if (i == 3) check("single_result", c0_rsp_result, exp);
            @(posedge clk); #1;
            c0_req_valid = 1'b0;
        end
        check("single_dev_req", dr, 5'b00010);
        check("single_rsp_valid", rv, 5'b01000);
        check("single_c1_quiet", c1v, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] ord;
        logic [6:0] dr3, rv3;
        logic       c1r, quiet;
        int         k, a0, a1, pulses, m;
        reset = 1'b0; rst3 = 1'b0;
        c0_req_valid = 1'b1; c0_y = 4'b0001; c0_opcode = 2'b00;
        c1_req_valid = 1'b1; c1_y = 4'b0010; c1_opcode = 2'b01;
        c0_rsp_ready = 1'b1; c1_rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {c0_req_ready, c1_req_ready, c0_rsp_valid, c1_rsp_valid, dev_req, busy,
                                    grant_id, dev_y, dev_opcode, c0_rsp_result, c1_rsp_result}, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        ord = 5'b01010; k = 0; a0 = 0; a1 = 0;
        for (int n = 0; n < 200 && k < 5; n++) begin
            @(negedge clk);
            if (c0_req_ready || c1_req_ready) begin
                check("grant_order", c1_req_ready, ord[k]);
                k++;
                if (c1_req_ready) a1++; else a0++;
            end
            @(posedge clk); #1;
            if (a0 == 3) c0_req_valid = 1'b0;
            if (a1 == 2) c1_req_valid = 1'b0;
        end
        check("contention_jobs", k, 5);
        drain("contention_drain");

        single(4'b0101, 2'b10, 4'b0111);
        single(4'b1111, 2'b11, 4'b0010);

        @(posedge clk); #1;
        c0_y = 4'b0100; c0_opcode = 2'b01; c0_req_valid = 1'b1; c0_rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_accept", c0_req_ready, 1);
        @(posedge clk); #1;
        c0_req_valid = 1'b0; c1_y = 4'b0110; c1_opcode = 2'b11; c1_req_valid = 1'b1;
        pulses = 0; c1r = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            pulses += int'(dev_req); c1r |= c1_req_ready;
            if (i >= 3) check("bp_hold", {c0_rsp_valid, c0_rsp_result}, {1'b1, 4'b0101});
            @(posedge clk); #1;
        end
        c0_rsp_ready = 1'b1;
        @(negedge clk);
        pulses += int'(dev_req); c1r |= c1_req_ready;
        check("bp_c1_blocked", c1r, 0);
        check("bp_dev_req_count", pulses, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_c1_accept", c1_req_ready, 1);
        @(posedge clk); #1;
        c1_req_valid = 1'b0;
        drain("bp_drain");

        @(posedge clk); #1;
        c0_y = 4'b0011; c0_opcode = 2'b00; c0_req_valid = 1'b1;
        @(negedge clk);
        check("rw_accept", c0_req_ready, 1);
        @(posedge clk); #1;
        c0_req_valid = 1'b0;
        @(posedge clk); #2;
        check("rw_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("rw_async", {busy, c0_rsp_valid, c1_rsp_valid, dev_req, grant_id}, 0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        quiet = 1'b0;
        repeat (6) begin
            @(negedge clk);
            quiet |= c0_rsp_valid | c1_rsp_valid | busy;
        end
        check("rw_no_rsp", quiet, 0);
        m = n_rsp;
        @(posedge clk); #1;
        c1_y = 4'b1000; c1_opcode = 2'b01; c1_req_valid = 1'b1;
        @(negedge clk);
        check("rw_c1_accept", c1_req_ready, 1);
        @(posedge clk); #1;
        c1_req_valid = 1'b0;
        drain("rw_drain");
        check("rw_c1_done", n_rsp - m, 1);

        @(posedge clk); #1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        c0_y = 4'b1010; c0_opcode = 2'b10; c0_req_valid = 1'b1;
        dr3 = '0; rv3 = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            dr3[i] = b_dev_req; rv3[i] = b_c0_rsp_valid;
            if (i == 0) check("l3_accept", b_c0_req_ready, 1);
            if (i == 5) check("l3_result", b_c0_rsp_result, 4'b1100);
            @(posedge clk); #1;
            c0_req_valid = 1'b0;
        end
        check("l3_dev_req", dr3, 7'b0000010);
        check("l3_rsp_valid", rv3, 7'b0100000);
        drain("final_drain");
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
